// File: rtl/gpio_io_ctrl_pkg.sv
// Shared encodings for the GPIO I/O initiator: op codes, FSM states,
// bank/register identifiers and the PIN/DDR/PORT address offsets.
package gpio_io_ctrl_pkg;

  localparam logic [2:0] OP_IN   = 3'd0;
  localparam logic [2:0] OP_OUT  = 3'd1;
  localparam logic [2:0] OP_SBI  = 3'd2;
  localparam logic [2:0] OP_CBI  = 3'd3;
  localparam logic [2:0] OP_SBIS = 3'd4;
  localparam logic [2:0] OP_SBIC = 3'd5;

  localparam int unsigned OFF_PIN  = 0;
  localparam int unsigned OFF_DDR  = 1;
  localparam int unsigned OFF_PORT = 2;

  // Writable targets, in enable index order: DDRA, PORTA, DDRB, PORTB
  localparam int unsigned NUM_WR = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RMW  = 2'd1,
    ST_EXEC = 2'd2
  } state_e;

  typedef enum logic {
    BANK_A = 1'b0,
    BANK_B = 1'b1
  } bank_e;

  typedef enum logic [1:0] {
    REG_PIN  = 2'd0,
    REG_DDR  = 2'd1,
    REG_PORT = 2'd2
  } reg_e;

  function automatic logic is_write_op(input logic [2:0] op);
    return (op == OP_OUT) || (op == OP_SBI) || (op == OP_CBI);
  endfunction

  function automatic logic is_rmw_op(input logic [2:0] op);
    return (op == OP_SBI) || (op == OP_CBI);
  endfunction

endpackage

// File: rtl/gpio_io_ctrl_addr_decode.sv
// Combinational I/O address decoder: maps an address onto bank A/B and
// register PIN/DDR/PORT, with hit=0 for anything outside the six registers.
module gpio_addr_decode
  import gpio_io_ctrl_pkg::*;
#(
  parameter int unsigned         ADDR_W    = 6,
  parameter logic [ADDR_W-1:0]   PINA_ADDR = 6'h19,
  parameter logic [ADDR_W-1:0]   PINB_ADDR = 6'h16
) (
  input  logic [ADDR_W-1:0] addr,
  output bank_e             bank,
  output reg_e              sel,
  output logic              hit
);

  localparam logic [ADDR_W-1:0] DDRA_ADDR  = PINA_ADDR + ADDR_W'(OFF_DDR);
  localparam logic [ADDR_W-1:0] PORTA_ADDR = PINA_ADDR + ADDR_W'(OFF_PORT);
  localparam logic [ADDR_W-1:0] DDRB_ADDR  = PINB_ADDR + ADDR_W'(OFF_DDR);
  localparam logic [ADDR_W-1:0] PORTB_ADDR = PINB_ADDR + ADDR_W'(OFF_PORT);

  always_comb begin
    bank = BANK_A;
    sel  = REG_PIN;
    hit  = 1'b0;
    if (addr == PINA_ADDR) begin
      bank = BANK_A; sel = REG_PIN;  hit = 1'b1;
    end else if (addr == DDRA_ADDR) begin
      bank = BANK_A; sel = REG_DDR;  hit = 1'b1;
    end else if (addr == PORTA_ADDR) begin
      bank = BANK_A; sel = REG_PORT; hit = 1'b1;
    end else if (addr == PINB_ADDR) begin
      bank = BANK_B; sel = REG_PIN;  hit = 1'b1;
    end else if (addr == DDRB_ADDR) begin
      bank = BANK_B; sel = REG_DDR;  hit = 1'b1;
    end else if (addr == PORTB_ADDR) begin
      bank = BANK_B; sel = REG_PORT; hit = 1'b1;
    end
  end

endmodule

// File: rtl/gpio_io_ctrl.sv
// CPU-side initiator for GPIO banks A/B: executes IN/OUT/SBI/CBI/SBIS/SBIC,
// with SBI/CBI done as a read-modify-write through an extra RMW state.
module gpio_io_ctrl
  import gpio_io_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 6,
  parameter logic [ADDR_W-1:0] PINA_ADDR = 6'h19,
  parameter logic [ADDR_W-1:0] PINB_ADDR = 6'h16
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_bit,
  input  logic [7:0]        req_wdata,
  output logic              done,
  output logic [7:0]        rdata,
  output logic              skip,
  output logic              addr_err,
  output logic              DDRA_write_enable,
  output logic [7:0]        DDRA_input_data,
  output logic              PORTA_write_enable,
  output logic [7:0]        PORTA_input_data,
  output logic              DDRB_write_enable,
  output logic [7:0]        DDRB_input_data,
  output logic              PORTB_write_enable,
  output logic [7:0]        PORTB_input_data,
  input  logic [7:0]        DDRA_output,
  input  logic [7:0]        PORTA_output,
  input  logic [7:0]        PINA_output,
  input  logic [7:0]        DDRB_output,
  input  logic [7:0]        PORTB_output,
  input  logic [7:0]        PINB_output
);

  state_e            state_reg, state_next;
  logic [2:0]        op_reg;
  logic [2:0]        bit_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [7:0]        data_reg;

  bank_e             dec_bank;
  reg_e              dec_sel;
  logic              dec_hit;

  logic              accept;
  logic              in_exec;
  logic              op_ok;
  logic              wr_fire;
  logic [1:0]        wr_idx;
  logic [7:0]        cur_val;
  logic [7:0]        bit_mask;
  logic [7:0]        rmw_val;
  logic [NUM_WR-1:0] wr_en;
  logic [7:0]        wr_data [NUM_WR];

  gpio_addr_decode #(
    .ADDR_W    (ADDR_W),
    .PINA_ADDR (PINA_ADDR),
    .PINB_ADDR (PINB_ADDR)
  ) u_decode (
    .addr (addr_reg),
    .bank (dec_bank),
    .sel  (dec_sel),
    .hit  (dec_hit)
  );

  assign accept  = req_valid && (state_reg == ST_IDLE);
  assign in_exec = (state_reg == ST_EXEC);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = is_rmw_op(req_op) ? ST_RMW : ST_EXEC;
      ST_RMW:  state_next = ST_EXEC;
      ST_EXEC: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cur_val = 8'h00;
    if (dec_hit) begin
      case (dec_sel)
        REG_PIN:  cur_val = (dec_bank == BANK_A) ? PINA_output  : PINB_output;
        REG_DDR:  cur_val = (dec_bank == BANK_A) ? DDRA_output  : DDRB_output;
        REG_PORT: cur_val = (dec_bank == BANK_A) ? PORTA_output : PORTB_output;
        default:  cur_val = 8'h00;
      endcase
    end
  end

  assign bit_mask = 8'h01 << bit_reg;
  assign rmw_val  = (op_reg == OP_SBI) ? (cur_val | bit_mask) : (cur_val & ~bit_mask);

  // data_reg carries OUT data from accept, or the modified byte after RMW
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_reg <= ST_IDLE;
      op_reg    <= 3'd0;
      addr_reg  <= '0;
      bit_reg   <= 3'd0;
      data_reg  <= 8'h00;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg   <= req_op;
        addr_reg <= req_addr;
        bit_reg  <= req_bit;
        data_reg <= req_wdata;
      end else if (state_reg == ST_RMW) begin
        data_reg <= rmw_val;
      end
    end
  end

  assign op_ok   = dec_hit && (op_reg <= OP_SBIC);
  assign wr_fire = in_exec && op_ok && is_write_op(op_reg) && (dec_sel != REG_PIN);
  assign wr_idx  = {dec_bank == BANK_B, dec_sel == REG_PORT};

  // Each target's data bus shows the new byte while enabled and holds it afterwards
  genvar gi;
  generate
    for (gi = 0; gi < NUM_WR; gi++) begin : g_wr
      logic [7:0] hold_reg;
      assign wr_en[gi]   = wr_fire && (wr_idx == 2'(gi));
      assign wr_data[gi] = wr_en[gi] ? data_reg : hold_reg;
      always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) hold_reg <= 8'h00;
        else        hold_reg <= wr_data[gi];
      end
    end
  endgenerate

  assign DDRA_write_enable  = wr_en[0];
  assign DDRA_input_data    = wr_data[0];
  assign PORTA_write_enable = wr_en[1];
  assign PORTA_input_data   = wr_data[1];
  assign DDRB_write_enable  = wr_en[2];
  assign DDRB_input_data    = wr_data[2];
  assign PORTB_write_enable = wr_en[3];
  assign PORTB_input_data   = wr_data[3];

  assign req_ready = (state_reg == ST_IDLE);
  assign done      = in_exec;
  assign rdata     = (in_exec && op_ok && (op_reg == OP_IN)) ? cur_val : 8'h00;
  assign addr_err  = in_exec && !op_ok;

  always_comb begin
    skip = 1'b0;
    if (in_exec && op_ok) begin
      if (op_reg == OP_SBIS)      skip = cur_val[bit_reg];
      else if (op_reg == OP_SBIC) skip = ~cur_val[bit_reg];
    end
  end

endmodule

// File: tb/tb_gpio_io_ctrl.sv
// Bench for gpio_io_ctrl: an address-map model predicts every op, a per-cycle
// compare checks all outputs, and directed literals pin the model.
module tb_gpio_io_ctrl;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_op = 3'd0;
  logic [5:0] req_addr = 6'd0;
  logic [2:0] req_bit = 3'd0;
  logic [7:0] req_wdata = 8'd0;
  logic       done, skip, addr_err;
  logic [7:0] rdata;
  logic       DDRA_write_enable, PORTA_write_enable, DDRB_write_enable, PORTB_write_enable;
  logic [7:0] DDRA_input_data, PORTA_input_data, DDRB_input_data, PORTB_input_data;
  logic [7:0] DDRA_output, PORTA_output, PINA_output;
  logic [7:0] DDRB_output, PORTB_output, PINB_output;

  // bank_val[bank][reg]: bank 0=A 1=B, reg 0=PIN 1=DDR 2=PORT
  logic [7:0] bank_val [2][3];

  always #5 clk = ~clk;

  assign PINA_output  = bank_val[0][0];
  assign DDRA_output  = bank_val[0][1];
  assign PORTA_output = bank_val[0][2];
  assign PINB_output  = bank_val[1][0];
  assign DDRB_output  = bank_val[1][1];
  assign PORTB_output = bank_val[1][2];

  gpio_io_ctrl dut (
    .clk                (clk),
    .clr_n              (clr_n),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_op             (req_op),
    .req_addr           (req_addr),
    .req_bit            (req_bit),
    .req_wdata          (req_wdata),
    .done               (done),
    .rdata              (rdata),
    .skip               (skip),
    .addr_err           (addr_err),
    .DDRA_write_enable  (DDRA_write_enable),
    .DDRA_input_data    (DDRA_input_data),
    .PORTA_write_enable (PORTA_write_enable),
    .PORTA_input_data   (PORTA_input_data),
    .DDRB_write_enable  (DDRB_write_enable),
    .DDRB_input_data    (DDRB_input_data),
    .PORTB_write_enable (PORTB_write_enable),
    .PORTB_input_data   (PORTB_input_data),
    .DDRA_output        (DDRA_output),
    .PORTA_output       (PORTA_output),
    .PINA_output        (PINA_output),
    .DDRB_output        (DDRB_output),
    .PORTB_output       (PORTB_output),
    .PINB_output        (PINB_output)
  );

  logic [3:0] dut_we;
  logic [7:0] dut_data [4];
  assign dut_we      = {PORTB_write_enable, DDRB_write_enable, PORTA_write_enable, DDRA_write_enable};
  assign dut_data[0] = DDRA_input_data;
  assign dut_data[1] = PORTA_input_data;
  assign dut_data[2] = DDRB_input_data;
  assign dut_data[3] = PORTB_input_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model of the pending op: what the EXEC cycle must show, and when
  int         acc_cyc  = -1;
  int         done_cyc = -1;
  logic [7:0] e_rdata  = 8'h00;
  logic       e_skip   = 1'b0;
  logic       e_err    = 1'b0;
  logic       e_wr     = 1'b0;
  int         e_idx    = 0;
  logic [7:0] e_val    = 8'h00;
  logic [7:0] e_hold [4];

  task automatic predict(input logic [2:0] op, input logic [5:0] addr,
                         input logic [2:0] b, input logic [7:0] wd);
    bit         mapped;
    int         bank;
    int         r;
    logic [7:0] cur;
    mapped  = (addr >= 6'h16) && (addr <= 6'h1B);
    bank    = (addr >= 6'h19) ? 0 : 1;
    r       = mapped ? (int'(addr) - ((bank == 0) ? 'h19 : 'h16)) : 0;
    cur     = mapped ? bank_val[bank][r] : 8'h00;
    e_err   = !mapped || (op > 3'd5);
    e_rdata = (!e_err && op == 3'd0) ? cur : 8'h00;
    e_skip  = !e_err && ((op == 3'd4 && cur[b]) || (op == 3'd5 && !cur[b]));
    e_wr    = !e_err && (op == 3'd1 || op == 3'd2 || op == 3'd3) && (r != 0);
    e_idx   = bank * 2 + ((r == 2) ? 1 : 0);
    case (op)
      3'd1:    e_val = wd;
      3'd2:    e_val = cur | (8'h01 << b);
      default: e_val = cur & ~(8'h01 << b);
    endcase
    acc_cyc  = cyc + 1;
    done_cyc = acc_cyc + ((op == 3'd2 || op == 3'd3) ? 1 : 0);
  endtask

  // Per-cycle compare of every output against the model
  initial begin
    forever begin
      logic busy, in_done;
      @(negedge clk);
      busy    = (acc_cyc >= 0) && (cyc >= acc_cyc) && (cyc <= done_cyc);
      in_done = (done_cyc >= 0) && (cyc == done_cyc);
      if (in_done && e_wr) e_hold[e_idx] = e_val;
      chk("req_ready", 8'(req_ready), 8'(!busy));
      chk("done",      8'(done),      8'(in_done));
      chk("rdata",     rdata,         in_done ? e_rdata : 8'h00);
      chk("skip",      8'(skip),      8'(in_done && e_skip));
      chk("addr_err",  8'(addr_err),  8'(in_done && e_err));
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("we%0d", i),   8'(dut_we[i]), 8'(in_done && e_wr && (e_idx == i)));
        chk($sformatf("data%0d", i), dut_data[i],   e_hold[i]);
      end
    end
  end

  logic       cap_done, cap_skip, cap_err;
  logic [7:0] cap_rdata;
  logic [3:0] cap_we;
  logic [7:0] cap_data [4];

  // Issue one op from IDLE, capture the EXEC cycle, return in the next IDLE cycle
  task automatic run_op(input logic [2:0] op, input logic [5:0] addr,
                        input logic [2:0] b, input logic [7:0] wd);
    predict(op, addr, b, wd);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_bit = b; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 3'd0; req_addr = 6'd0; req_bit = 3'd0; req_wdata = 8'd0;
    if (op == 3'd2 || op == 3'd3) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    cap_done = done; cap_rdata = rdata; cap_skip = skip; cap_err = addr_err; cap_we = dut_we;
    for (int i = 0; i < 4; i++) cap_data[i] = dut_data[i];
    $display("op=%0d addr=%02h bit=%0d wdata=%02h -> done=%b rdata=%02h skip=%b err=%b we=%b",
             op, addr, b, wd, cap_done, cap_rdata, cap_skip, cap_err, cap_we);
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) e_hold[i] = 8'h00;
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 3; r++) bank_val[b][r] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 8'(req_ready), 8'h01);
    chk("rst_done",  8'(done),      8'h00);
    chk("rst_ddra",  DDRA_input_data, 8'h00);
    clr_n = 1'b1;
    @(posedge clk); #1;

    run_op(3'd1, 6'h1A, 3'd0, 8'hA5);
    chk("out_done", 8'(cap_done), 8'h01);
    chk("out_we",   8'(cap_we),   8'h01);
    chk("out_data", cap_data[0],  8'hA5);
    chk("out_ready_after", 8'(req_ready), 8'h01);

    bank_val[1][2] = 8'h00;
    run_op(3'd2, 6'h18, 3'd3, 8'h00);
    chk("sbi_we",   8'(cap_we),  8'h08);
    chk("sbi_data", cap_data[3], 8'h08);
    chk("sbi_done", 8'(cap_done), 8'h01);

    bank_val[0][2] = 8'hFF;
    run_op(3'd3, 6'h1B, 3'd7, 8'h00);
    chk("cbi_we",   8'(cap_we),  8'h02);
    chk("cbi_data", cap_data[1], 8'h7F);

    bank_val[0][0] = 8'h01;
    run_op(3'd4, 6'h19, 3'd0, 8'h00);
    chk("sbis_skip", 8'(cap_skip), 8'h01);
    chk("sbis_we",   8'(cap_we),   8'h00);

    bank_val[1][0] = 8'h3C;
    run_op(3'd0, 6'h16, 3'd0, 8'h00);
    chk("in_rdata", cap_rdata,     8'h3C);
    chk("in_err",   8'(cap_err),   8'h00);

    run_op(3'd0, 6'h30, 3'd0, 8'h00);
    chk("in_unmapped_err",   8'(cap_err), 8'h01);
    chk("in_unmapped_rdata", cap_rdata,   8'h00);
    chk("in_unmapped_we",    8'(cap_we),  8'h00);

    run_op(3'd1, 6'h19, 3'd0, 8'hFF);
    chk("out_pin_done", 8'(cap_done), 8'h01);
    chk("out_pin_err",  8'(cap_err),  8'h00);
    chk("out_pin_we",   8'(cap_we),   8'h00);

    bank_val[1][1] = 8'h04;
    run_op(3'd5, 6'h17, 3'd2, 8'h00);
    chk("sbic_set_skip", 8'(cap_skip), 8'h00);
    run_op(3'd5, 6'h17, 3'd1, 8'h00);
    chk("sbic_clr_skip", 8'(cap_skip), 8'h01);

    run_op(3'd6, 6'h1A, 3'd0, 8'h55);
    chk("rsvd_err", 8'(cap_err), 8'h01);
    chk("rsvd_we",  8'(cap_we),  8'h00);

    run_op(3'd1, 6'h1B, 3'd0, 8'h3C);
    run_op(3'd1, 6'h18, 3'd0, 8'hC3);
    chk("hold_ddra",  DDRA_input_data,  8'hA5);
    chk("hold_porta", PORTA_input_data, 8'h3C);

    // SBI aborted by reset during its RMW cycle
    bank_val[0][2] = 8'h00;
    predict(3'd2, 6'h1B, 3'd4, 8'h00);
    req_valid = 1'b1; req_op = 3'd2; req_addr = 6'h1B; req_bit = 3'd4; req_wdata = 8'h00;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 3'd0; req_addr = 6'd0; req_bit = 3'd0;
    chk("rmw_busy", 8'(req_ready), 8'h00);
    #2;
    clr_n = 1'b0;
    acc_cyc = -1; done_cyc = -1;
    for (int i = 0; i < 4; i++) e_hold[i] = 8'h00;
    $display("op=2 addr=1b bit=4 wdata=00 -> reset during RMW");
    repeat (2) @(posedge clk);
    #1;
    clr_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_ready", 8'(req_ready), 8'h01);
    chk("post_rst_porta", PORTA_input_data, 8'h00);

    run_op(3'd1, 6'h17, 3'd0, 8'h5A);
    chk("post_rst_out_we",   8'(cap_we),  8'h04);
    chk("post_rst_out_data", cap_data[2], 8'h5A);

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
